// File: rtl/linear_buffer_ctrl.sv
// Pointer/occupancy controller for a DEPTH+1 entry circular buffer with multi-entry push/pop.
// Optional sticky overflow/underflow flags are built when LINEAR_BUFFER_CTRL_ERR_EN is defined.
module linear_buffer_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  buf_wen,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
`ifdef LINEAR_BUFFER_CTRL_ERR_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  localparam logic [ADDR_WIDTH:0] SLOTS  = (ADDR_WIDTH+1)'(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] WR_MAX = (ADDR_WIDTH+1)'(DEPTH + 1 - PAR_WRITE);
  localparam logic [ADDR_WIDTH:0] PW_C   = (ADDR_WIDTH+1)'(PAR_WRITE);
  localparam logic [ADDR_WIDTH:0] PR_C   = (ADDR_WIDTH+1)'(PAR_READ);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;

  // Advance with wrap over DEPTH+1 slots; n never exceeds DEPTH+1, so one subtraction suffices.
  function automatic logic [ADDR_WIDTH-1:0] adv(input logic [ADDR_WIDTH-1:0] p,
                                                input logic [ADDR_WIDTH:0]   n);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, p} + n;
    if (s >= SLOTS) s = s - SLOTS;
    return s[ADDR_WIDTH-1:0];
  endfunction

  // Free room compared as count <= DEPTH+1-PAR_WRITE to stay unsigned-safe.
  assign wr_ready  = !flush && (count_q <= WR_MAX);
  assign rd_valid  = !flush && (count_q >= PR_C);
  // rst_n gating keeps a write from escaping while reset is held.
  assign push      = wr_valid && wr_ready && rst_n;
  assign pop       = rd_valid && rd_ready;
  assign buf_wen   = push;
  assign buf_waddr = wptr_q;
  assign buf_raddr = rptr_q;
  assign count     = count_q;
  assign full      = (count_q == SLOTS);
  assign empty     = (count_q == '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = adv(wptr_q, PW_C);
      if (pop)  rptr_d = adv(rptr_q, PR_C);
      count_d = count_q + (push ? PW_C : '0) - (pop ? PR_C : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

`ifdef LINEAR_BUFFER_CTRL_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) ovf_q <= 1'b1;
      if (rd_ready && !rd_valid) udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_linear_buffer_ctrl.sv
// Bench for linear_buffer_ctrl at DEPTH=4, PAR_WRITE=2, PAR_READ=1: directed scenarios plus an entry scoreboard.
module tb_linear_buffer_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 4;
  localparam int PW = 2;
  localparam int PR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic wr_ready, rd_valid, buf_wen, full, empty;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [AW:0] count;
`ifdef LINEAR_BUFFER_CTRL_ERR_EN
  logic ovf_err, udf_err;
`endif

  int checks = 0;
  int failures = 0;

  linear_buffer_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr),
    .count(count), .full(full), .empty(empty)
`ifdef LINEAR_BUFFER_CTRL_ERR_EN
    , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: each queued int is the buffer address of one stored entry, oldest first.
  int sbq[$];
  int m_wptr = 0;
  bit p_flush = 0, p_push = 0, p_pop = 0;

  always @(negedge clk) begin
    bit exp_wr, exp_rd, exp_wen;
    if (rst_n) begin
      exp_wr  = !flush && ((DEPTH + 1 - sbq.size()) >= PW);
      exp_rd  = !flush && (sbq.size() >= PR);
      exp_wen = wr_valid && exp_wr;
      checks++;
      if (wr_ready !== exp_wr || rd_valid !== exp_rd || buf_wen !== exp_wen) begin
        failures++;
        $display("FAIL sb_hs got wr_ready=%b rd_valid=%b buf_wen=%b exp %b %b %b",
                 wr_ready, rd_valid, buf_wen, exp_wr, exp_rd, exp_wen);
      end
      checks++;
      if (count !== (AW+1)'(sbq.size()) || empty !== (sbq.size() == 0) ||
          full !== (sbq.size() == DEPTH + 1) || buf_waddr !== AW'(m_wptr)) begin
        failures++;
        $display("FAIL sb_state got count=%0d empty=%b full=%b waddr=%0d exp count=%0d waddr=%0d",
                 count, empty, full, buf_waddr, sbq.size(), m_wptr);
      end
      if (exp_rd) begin
        checks++;
        if (buf_raddr !== AW'(sbq[0])) begin
          failures++;
          $display("FAIL sb_raddr got=%0d exp=%0d", buf_raddr, sbq[0]);
        end
      end
      p_flush = flush;
      p_push  = exp_wen;
      p_pop   = exp_rd && rd_ready;
    end else begin
      checks++;
      if (buf_wen !== 1'b0 || count !== '0) begin
        failures++;
        $display("FAIL sb_in_reset got buf_wen=%b count=%0d exp 0 0", buf_wen, count);
      end
      p_flush = 0; p_push = 0; p_pop = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || p_flush) begin
      sbq.delete();
      m_wptr = 0;
    end else begin
      if (p_pop) for (int i = 0; i < PR; i++) void'(sbq.pop_front());
      if (p_push) begin
        for (int i = 0; i < PW; i++) sbq.push_back((m_wptr + i) % (DEPTH + 1));
        m_wptr = (m_wptr + PW) % (DEPTH + 1);
      end
    end
    p_flush = 0; p_push = 0; p_pop = 0;
  end

  // Drive inputs just after a rising edge, then let combinational outputs settle.
  task automatic step(input logic wv, input logic rr, input logic fl);
    @(posedge clk);
    #2;
    wr_valid = wv; rd_ready = rr; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1;
    #3;
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1 ||
        rd_valid !== 1'b0 || buf_wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got count=%0d empty=%b full=%b wr_ready=%b rd_valid=%b buf_wen=%b exp 0 1 0 1 0 0",
               count, empty, full, wr_ready, rd_valid, buf_wen);
    end
    @(posedge clk); @(posedge clk); #2;
    wr_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_fill();
    step(1, 0, 0);
    checks++;
    if (buf_wen !== 1'b1 || buf_waddr !== 4'd0 || count !== 5'd0) begin
      failures++;
      $display("FAIL fill_first got wen=%b waddr=%0d count=%0d exp 1 0 0", buf_wen, buf_waddr, count);
    end
    step(1, 0, 0);
    checks++;
    if (buf_wen !== 1'b1 || buf_waddr !== 4'd2 || count !== 5'd2) begin
      failures++;
      $display("FAIL fill_second got wen=%b waddr=%0d count=%0d exp 1 2 2", buf_wen, buf_waddr, count);
    end
    step(1, 0, 0);
    checks++;
    if (wr_ready !== 1'b0 || buf_wen !== 1'b0 || count !== 5'd4 || full !== 1'b0) begin
      failures++;
      $display("FAIL fill_blocked got wr_ready=%b wen=%b count=%0d full=%b exp 0 0 4 0",
               wr_ready, buf_wen, count, full);
    end
    step(0, 0, 0);
    checks++;
    if (count !== 5'd4 || buf_waddr !== 4'd4) begin
      failures++;
      $display("FAIL fill_hold got count=%0d waddr=%0d exp 4 4", count, buf_waddr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      checks++;
      if (rd_valid !== 1'b1 || buf_raddr !== AW'(i)) begin
        failures++;
        $display("FAIL wrap_pop%0d got rd_valid=%b raddr=%0d exp 1 %0d", i, rd_valid, buf_raddr, i);
      end
    end
    step(1, 0, 0);
    checks++;
    if (count !== 5'd1 || buf_raddr !== 4'd3 || buf_wen !== 1'b1 || buf_waddr !== 4'd4) begin
      failures++;
      $display("FAIL wrap_push got count=%0d raddr=%0d wen=%b waddr=%0d exp 1 3 1 4",
               count, buf_raddr, buf_wen, buf_waddr);
    end
    step(0, 0, 0);
    checks++;
    if (count !== 5'd3 || buf_waddr !== 4'd1) begin
      failures++;
      $display("FAIL wrap_after got count=%0d waddr=%0d exp 3 1", count, buf_waddr);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0);
    checks++;
    if (buf_wen !== 1'b1 || rd_valid !== 1'b1 || buf_waddr !== 4'd1 || buf_raddr !== 4'd3) begin
      failures++;
      $display("FAIL simul_req got wen=%b rd_valid=%b waddr=%0d raddr=%0d exp 1 1 1 3",
               buf_wen, rd_valid, buf_waddr, buf_raddr);
    end
    step(0, 0, 0);
    checks++;
    if (count !== 5'd4 || buf_waddr !== 4'd3 || buf_raddr !== 4'd4) begin
      failures++;
      $display("FAIL simul_after got count=%0d waddr=%0d raddr=%0d exp 4 3 4", count, buf_waddr, buf_raddr);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || buf_raddr !== 4'd3) begin
      failures++;
      $display("FAIL drain_empty got count=%0d empty=%b rd_valid=%b raddr=%0d exp 0 1 0 3",
               count, empty, rd_valid, buf_raddr);
    end
    step(0, 0, 0);
    checks++;
    if (buf_raddr !== 4'd3 || count !== 5'd0) begin
      failures++;
      $display("FAIL drain_hold got raddr=%0d count=%0d exp 3 0", buf_raddr, count);
    end
`ifdef LINEAR_BUFFER_CTRL_ERR_EN
    checks++;
    if (udf_err !== 1'b1 || ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got udf=%b ovf=%b exp 1 1", udf_err, ovf_err);
    end
`endif
  endtask

  task automatic test_flush();
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    checks++;
    if (count !== 5'd3 || buf_wen !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got count=%0d wen=%b wr_ready=%b rd_valid=%b exp 3 0 0 0",
               count, buf_wen, wr_ready, rd_valid);
    end
    step(0, 0, 0);
    checks++;
    if (count !== 5'd0 || buf_waddr !== 4'd0 || buf_raddr !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL flush_after got count=%0d waddr=%0d raddr=%0d empty=%b exp 0 0 0 1",
               count, buf_waddr, buf_raddr, empty);
    end
`ifdef LINEAR_BUFFER_CTRL_ERR_EN
    checks++;
    if (udf_err !== 1'b0 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_err got udf=%b ovf=%b exp 0 0", udf_err, ovf_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (buf_wen !== 1'b1 || count !== 5'd2 || buf_waddr !== 4'd2) begin
      failures++;
      $display("FAIL arst_pre got wen=%b count=%0d waddr=%0d exp 1 2 2", buf_wen, count, buf_waddr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (buf_wen !== 1'b0 || count !== 5'd0 || buf_waddr !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL arst_mid got wen=%b count=%0d waddr=%0d empty=%b exp 0 0 0 1",
               buf_wen, count, buf_waddr, empty);
    end
    @(posedge clk); #2;
    wr_valid = 1'b0; rst_n = 1'b1;
    step(0, 0, 0);
    checks++;
    if (count !== 5'd0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_after got count=%0d wr_ready=%b exp 0 1", count, wr_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_drain();
    test_flush();
    test_async_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/linear_buffer_ctrl.md
LINEAR_BUFFER_CTRL -- requirements
Module: linear_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: width of the buffer address ports.
REQ-002 SHALL have parameter DEPTH, default 4: the buffer holds DEPTH+1 entries, addresses 0..DEPTH.
REQ-003 SHALL have parameter PAR_WRITE, default 1: entries pushed per accepted write.
REQ-004 SHALL have parameter PAR_READ, default 1: entries popped per accepted read.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1: synchronous clear of all pointers and occupancy.
REQ-008 SHALL have ports wr_valid (input, 1) and wr_ready (output, 1): the producer push handshake.
REQ-009 SHALL have ports rd_valid (output, 1) and rd_ready (input, 1): the consumer pop handshake.
REQ-010 SHALL have ports buf_wen (output, 1), buf_waddr (output, ADDR_WIDTH) and buf_raddr (output, ADDR_WIDTH): buffer control.
REQ-011 SHALL have port count, output, ADDR_WIDTH+1: occupied entries.
REQ-012 SHALL have ports full and empty, outputs, 1 each.

Function
REQ-013 SHALL keep registered wptr, rptr (0..DEPTH) and count (0..DEPTH+1).
REQ-014 SHALL drive wr_ready = !flush && (DEPTH+1-count >= PAR_WRITE), and rd_valid = !flush && (count >= PAR_READ), combinationally from registered state.
REQ-015 SHALL accept a push when wr_valid && wr_ready, driving buf_wen=1 in that cycle with buf_waddr=wptr.
REQ-016 SHALL drive buf_raddr=rptr continuously and accept a pop when rd_valid && rd_ready.
REQ-017 SHALL advance a pointer by N (PAR_WRITE or PAR_READ) with wrap: next = ptr+N when ptr+N <= DEPTH, else ptr+N-DEPTH-1.
REQ-018 SHALL update count on the accepting edge: +PAR_WRITE on push only, -PAR_READ on pop only, +PAR_WRITE-PAR_READ on simultaneous push and pop.
REQ-019 SHALL make data pushed at edge k poppable from cycle k+1 (zero-bubble). A pop in the same cycle as a push sees only entries counted before that edge.
REQ-020 SHALL assert full when count == DEPTH+1 and empty when count == 0.
REQ-021 SHALL give flush priority over push and pop: buf_wen=0 during flush; wptr, rptr and count become 0 on that edge.
REQ-022 SHALL ignore wr_valid while wr_ready=0 and rd_ready while rd_valid=0, leaving all state unchanged.
REQ-023 SHALL require PAR_WRITE and PAR_READ to be in 1..DEPTH+1, and DEPTH < 2^ADDR_WIDTH; other values are unsupported.

Reset
REQ-024 SHALL on rst_n=0 immediately set wptr=0, rptr=0 and count=0, giving empty=1, full=0, wr_ready=1 (when PAR_WRITE<=DEPTH+1), rd_valid=0 and buf_wen=0.
REQ-025 SHALL abandon any in-flight handshake when reset is asserted mid-operation; no write is issued in a cycle with rst_n=0.

Configuration
REQ-026 SHALL, when LINEAR_BUFFER_CTRL_ERR_EN is defined, add outputs ovf_err and udf_err (1 bit each, reset 0). The flags are sticky: ovf_err sets on wr_valid && !wr_ready && !flush, and udf_err sets on rd_ready && !rd_valid && !flush. Both clear on flush.
REQ-027 SHALL, when LINEAR_BUFFER_CTRL_ERR_EN is undefined, omit both ports and all associated logic, with otherwise identical behaviour.

Verification (DEPTH=4, PAR_WRITE=2, PAR_READ=1, ADDR_WIDTH=4)
REQ-028 SHALL cover reset and fill:
- release rst_n, then hold wr_valid for 3 cycles -> buf_waddr 0 then 2;
- count 2 then 4; wr_ready=0 on the third cycle, no buf_wen.
REQ-029 SHALL cover wrap-around:
- from count=4 (wptr=4), pop 3 -> rptr=3, count=1;
- push -> buf_waddr=4, next wptr=1, count=3.
REQ-030 SHALL cover simultaneous push and pop at count=3 -> count=4 and both pointers advance in the same edge.
REQ-031 SHALL cover drain to empty:
- pop until count=0 -> empty=1, rd_valid=0;
- rd_ready held high causes no rptr change (and udf_err=1 with LINEAR_BUFFER_CTRL_ERR_EN).
REQ-032 SHALL cover flush with wr_valid=1 and rd_ready=1 at count=3 -> buf_wen=0, then wptr=rptr=count=0 with error flags cleared.
REQ-033 SHALL cover asynchronous reset asserted mid-push -> buf_wen drops in that cycle and count=0 without waiting for clk.
